// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button conditioning block.
package button_debounce_pkg;

    // Debounce FSM encoding; values are fixed so external tools can decode the state.
    typedef enum logic [1:0] {
        IdleLo = 2'd0,
        WaitHi = 2'd1,
        IdleHi = 2'd2,
        WaitLo = 2'd3
    } state_e;

    // 20 ms of stable input at the 12 MHz board clock.
    localparam int unsigned DebounceCycles12Mhz = 240000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw bit through two flops to resolve metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Synchronises a raw button pin and debounces it with a stable-count FSM.
// Produces a clean level, one-cycle rise/fall pulses and a press-toggled level.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCycles12Mhz,
    parameter int unsigned CNT_W           = 18,
    parameter bit          BTN_ACTIVE      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic toggle
);

    // Last count value before the level is allowed to change.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             btn_pol;
    logic             btn_s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             toggle_q;

    // Normalise so that 1 always means "pressed" before synchronising.
    assign btn_pol = BTN_ACTIVE ? btn_in : ~btn_in;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_pol),
        .q_o   (btn_s)
    );

    // Debounce FSM, stable counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IdleLo;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IdleLo: begin
                    if (btn_s) begin
                        state_q <= WaitHi;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WaitHi: begin
                    if (!btn_s) begin
                        // Bounce: drop back without touching the outputs.
                        state_q <= IdleLo;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q  <= IdleHi;
                        cnt_q    <= '0;
                        level_q  <= 1'b1;
                        rise_q   <= 1'b1;
                        toggle_q <= ~toggle_q;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                IdleHi: begin
                    if (!btn_s) begin
                        state_q <= WaitLo;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WaitLo: begin
                    if (btn_s) begin
                        state_q <= IdleHi;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= IdleLo;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= IdleLo;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign toggle    = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES = 4.
module tb_button_debounce;
    import button_debounce_pkg::*;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic btn    = 1'b0;
    logic btn_n  = 1'b1;
    logic lvl, rise, fall, tog;
    logic lvl2, rise2, fall2, tog2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .BTN_ACTIVE      (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn),
        .btn_level (lvl),
        .btn_rise  (rise),
        .btn_fall  (fall),
        .toggle    (tog)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .BTN_ACTIVE      (1'b0)
    ) dut_n (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_n),
        .btn_level (lvl2),
        .btn_rise  (rise2),
        .btn_fall  (fall2),
        .toggle    (tog2)
    );

    // One active edge, then sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn   = 1'b0;
        btn_n = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b0;
        btn   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({lvl, rise, fall, tog} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold i=%0d got %b want 0000", i, {lvl, rise, fall, tog});
            end
        end
        // Button still held as reset releases: counts as a fresh press.
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = {i >= 6, i == 6, 1'b0, i >= 6};
            checks++;
            if ({lvl, rise, fall, tog} !== exp) begin
                errors++;
                $display("FAIL reset_held_press i=%0d got %b want %b", i,
                         {lvl, rise, fall, tog}, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp;
        do_reset();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = {i >= 6, i == 6, 1'b0, i >= 6};
            checks++;
            if ({lvl, rise, fall, tog} !== exp) begin
                errors++;
                $display("FAIL clean_press i=%0d got %b want %b", i, {lvl, rise, fall, tog}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        logic [3:0] exp;
        pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
        do_reset();
        for (int k = 0; k < 5; k++) begin
            btn = pat[k];
            tick();
            checks++;
            if ({lvl, rise, fall, tog} !== 4'b0000) begin
                errors++;
                $display("FAIL bounce_quiet k=%0d got %b want 0000", k, {lvl, rise, fall, tog});
            end
        end
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = {i >= 6, i == 6, 1'b0, i >= 6};
            checks++;
            if ({lvl, rise, fall, tog} !== exp) begin
                errors++;
                $display("FAIL bounce_settle i=%0d got %b want %b", i, {lvl, rise, fall, tog}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        do_reset();
        // Three high samples: the count reaches its limit but never crosses it.
        btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if ({lvl, rise, fall, tog} !== 4'b0000) begin
                errors++;
                $display("FAIL glitch3 i=%0d got %b want 0000", i, {lvl, rise, fall, tog});
            end
            if (i == 3) btn = 1'b0;
        end
        // Four high samples: exactly the threshold, so a press and release follow.
        btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp = {i >= 6 && i < 10, i == 6, i == 10, i >= 6};
            checks++;
            if ({lvl, rise, fall, tog} !== exp) begin
                errors++;
                $display("FAIL pulse4 i=%0d got %b want %b", i, {lvl, rise, fall, tog}, exp);
            end
            if (i == 4) btn = 1'b0;
        end
    endtask

    task automatic test_two_presses();
        logic [3:0] exp;
        do_reset();
        btn = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp = {(i >= 6 && i < 16) || i >= 26, i == 6 || i == 26, i == 16,
                   i >= 6 && i < 26};
            checks++;
            if ({lvl, rise, fall, tog} !== exp) begin
                errors++;
                $display("FAIL two_presses i=%0d got %b want %b", i, {lvl, rise, fall, tog}, exp);
            end
            btn = !(i >= 10 && i < 20);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        btn = 1'b1;
        repeat (4) tick();
        checks++;
        if (dut.state_q !== WaitHi || dut.cnt_q !== 3'd2) begin
            errors++;
            $display("FAIL mid_wait_hi_setup got state %0d cnt %0d want 1 2",
                     dut.state_q, dut.cnt_q);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== IdleLo || dut.cnt_q !== 3'd0 || {lvl, rise, fall, tog} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_wait_hi_clear got state %0d cnt %0d out %b want 0 0 0000",
                     dut.state_q, dut.cnt_q, {lvl, rise, fall, tog});
        end
        btn = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if ({lvl, rise, fall, tog} !== 4'b0000) begin
                errors++;
                $display("FAIL after_mid_reset i=%0d got %b want 0000", i, {lvl, rise, fall, tog});
            end
        end
        // Reset while waiting to release: level and toggle must drop at once.
        btn = 1'b1;
        repeat (6) tick();
        btn = 1'b0;
        repeat (4) tick();
        checks++;
        if (dut.state_q !== WaitLo || {lvl, rise, fall, tog} !== 4'b1001) begin
            errors++;
            $display("FAIL mid_wait_lo_setup got state %0d out %b want 3 1001",
                     dut.state_q, {lvl, rise, fall, tog});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({lvl, rise, fall, tog} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_wait_lo_clear got %b want 0000", {lvl, rise, fall, tog});
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_active_low();
        logic [3:0] exp;
        do_reset();
        btn_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = {i >= 6, i == 6, 1'b0, i >= 6};
            checks++;
            if ({lvl2, rise2, fall2, tog2} !== exp) begin
                errors++;
                $display("FAIL active_low i=%0d got %b want %b", i,
                         {lvl2, rise2, fall2, tog2}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_two_presses();
        test_reset_mid_wait();
        test_active_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
